// File: rtl/bram_pkg.sv
// Shared constants, FSM encoding and byte-lane merge helper for the byte-enabled block RAM.
package bram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    // Widest word the merge helper handles; callers widen and truncate by cast.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } bramState_t;

    typedef logic [MAX_DATA_WIDTH-1:0] maxWord_t;
    typedef logic [MAX_BYTES-1:0]      maxMask_t;

    function automatic maxWord_t merge_bytes(input maxWord_t oldWord,
                                             input maxWord_t newWord,
                                             input maxMask_t mask);
        maxWord_t merged;
        merged = oldWord;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (mask[i]) merged[8*i +: 8] = newWord[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset sequencer: optionally zero-fills every word, then raises ready.
module bram_clear_seq
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ready,
    output logic                  clearEnable,
    output logic [ADDR_WIDTH-1:0] clearAddress,
    output logic [DATA_WIDTH-1:0] clearData
);

    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

    // One spare bit so the terminal compare never aliases on wrap.
    typedef logic [ADDR_WIDTH:0] count_t;
    localparam count_t LAST_ADDRESS = count_t'(MEM_DEPTH - 1);

    bramState_t state, nextState;
    count_t     count, nextCount;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            count <= '0;
            ready <= 1'b0;
        end else begin
            state <= nextState;
            count <= nextCount;
            ready <= (nextState == ST_RUN);
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        nextState   = state;
        nextCount   = count;
        clearEnable = 1'b0;
        case (state)
            ST_CLEAR: begin
                clearEnable = ~reset;
                nextCount   = count + count_t'(1);
                if (count == LAST_ADDRESS) nextState = ST_RUN;
            end
            default: ;
        endcase
    end

    assign clearAddress = count[ADDR_WIDTH-1:0];
    assign clearData    = '0;

endmodule

// File: rtl/bram_be_pipelined.sv
// Simple dual-port block RAM with byte write enables, 1/2-cycle read latency and read-during-write policy.
module bram_be_pipelined
    import bram_pkg::*;
#(
    parameter int    DATA_WIDTH     = 32,
    parameter int    ADDR_WIDTH     = 8,
    parameter int    READ_LATENCY   = 1,
    parameter int    RDW_MODE       = 0,
    parameter int    CLEAR_ON_RESET = 0,
    parameter string INIT_FILE      = ""
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    readEnable,
    input  logic [ADDR_WIDTH-1:0]   readAddress,
    output logic [DATA_WIDTH-1:0]   readData,
    output logic                    readValid,
    input  logic                    writeEnable,
    input  logic [DATA_WIDTH/8-1:0] writeByteEnable,
    input  logic [ADDR_WIDTH-1:0]   writeAddress,
    input  logic [DATA_WIDTH-1:0]   writeData,
    output logic                    ready
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [NUM_BYTES-1:0]  mask_t;

    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : gBadWidth
        $error("bram_be_pipelined: DATA_WIDTH must be a multiple of 8 and at most %0d", MAX_DATA_WIDTH);
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gBadLatency
        $error("bram_be_pipelined: READ_LATENCY must be 1 or 2");
    end
    if (RDW_MODE != RDW_WRITE_FIRST && RDW_MODE != RDW_READ_FIRST) begin : gBadRdw
        $error("bram_be_pipelined: RDW_MODE must be 0 or 1");
    end

    // NOTE: the array has no reset; zeroing is a word-per-cycle job for the sequencer so it still maps to block RAM.
    (* ram_style = "block" *) word_t ram [MEM_DEPTH];

    logic                  clearEnable;
    logic [ADDR_WIDTH-1:0] clearAddress;
    word_t                 clearData;

    bram_clear_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) clearSeq (
        .clock       (clock),
        .reset       (reset),
        .ready       (ready),
        .clearEnable (clearEnable),
        .clearAddress(clearAddress),
        .clearData   (clearData)
    );

    logic acceptRead, acceptWrite;
    assign acceptRead  = ready & readEnable & ~reset;
    assign acceptWrite = ready & writeEnable & ~reset;

    // Clear writes and user writes are exclusive: ready is low for the whole clear.
    logic                  portEnable;
    logic [ADDR_WIDTH-1:0] portAddress;
    word_t                 portData;
    mask_t                 portMask;

    always_comb begin
        portEnable  = acceptWrite;
        portAddress = writeAddress;
        portData    = writeData;
        portMask    = writeByteEnable;
        if (clearEnable) begin
            portEnable  = 1'b1;
            portAddress = clearAddress;
            portData    = clearData;
            portMask    = '1;
        end
    end

    always_ff @(posedge clock) begin
        if (portEnable) begin
            ram[portAddress] <= word_t'(merge_bytes(maxWord_t'(ram[portAddress]),
                                                    maxWord_t'(portData),
                                                    maxMask_t'(portMask)));
        end
    end

    word_t storedWord, readWord;

    always_comb begin
        storedWord = ram[readAddress];
        readWord   = storedWord;
        if (RDW_MODE == RDW_WRITE_FIRST && acceptWrite && writeAddress == readAddress) begin
            readWord = word_t'(merge_bytes(maxWord_t'(storedWord),
                                           maxWord_t'(writeData),
                                           maxMask_t'(writeByteEnable)));
        end
    end

    logic  stage1Valid;
    word_t stage1Data;

    always_ff @(posedge clock) begin
        if (reset) begin
            stage1Valid <= 1'b0;
            stage1Data  <= '0;
        end else begin
            stage1Valid <= acceptRead;
            stage1Data  <= acceptRead ? readWord : '0;
        end
    end

    if (READ_LATENCY == 2) begin : gOutReg
        logic  stage2Valid;
        word_t stage2Data;

        always_ff @(posedge clock) begin
            if (reset) begin
                stage2Valid <= 1'b0;
                stage2Data  <= '0;
            end else begin
                stage2Valid <= stage1Valid;
                stage2Data  <= stage1Data;
            end
        end

        assign readValid = stage2Valid;
        assign readData  = stage2Data;
    end else begin : gNoOutReg
        assign readValid = stage1Valid;
        assign readData  = stage1Data;
    end

endmodule

// File: tb/tb_bram_be_pipelined.sv
// Bench: two instances (latency 1 write-first, latency 2 read-first) share stimulus and a behavioural model.
module tb_bram_be_pipelined;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          readEnable = 1'b0;
    logic [AW-1:0] readAddress = '0;
    logic          writeEnable = 1'b0;
    logic [3:0]    writeByteEnable = '0;
    logic [AW-1:0] writeAddress = '0;
    logic [DW-1:0] writeData = '0;

    logic [DW-1:0] rdA, rdB;
    logic          rvA, rvB, rdyA, rdyB;

    always #5 clock = ~clock;

    bram_be_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
        .RDW_MODE(0), .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) dutA (
        .clock(clock), .reset(reset),
        .readEnable(readEnable), .readAddress(readAddress),
        .readData(rdA), .readValid(rvA),
        .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
        .writeAddress(writeAddress), .writeData(writeData),
        .ready(rdyA)
    );

    bram_be_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
        .RDW_MODE(1), .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) dutB (
        .clock(clock), .reset(reset),
        .readEnable(readEnable), .readAddress(readAddress),
        .readData(rdB), .readValid(rvB),
        .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
        .writeAddress(writeAddress), .writeData(writeData),
        .ready(rdyB)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Behavioural model: memory array, clear countdown, per-instance expected outputs.
    logic [31:0] mem [DEPTH];
    bit          modelStarted = 1'b0;
    bit          mReady = 1'b0;
    int          clearLeft = 0;
    logic        expAv = 1'b0, expBv = 1'b0, pendBv = 1'b0;
    logic [31:0] expAd = '0, expBd = '0, pendBd = '0;

    function automatic logic [31:0] laneMerge(input logic [31:0] oldW, input logic [31:0] newW, input logic [3:0] mask);
        logic [31:0] r;
        r = oldW;
        for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = newW[8*b +: 8];
        return r;
    endfunction

    always @(posedge clock) begin : model
        logic        accR, accW;
        logic [31:0] oldW, newW, wfW;
        if (reset) begin
            modelStarted = 1'b1;
            mReady    = 1'b0;
            clearLeft = DEPTH;
            expAv = 1'b0; expAd = '0;
            expBv = 1'b0; expBd = '0;
            pendBv = 1'b0; pendBd = '0;
        end else begin
            accR = mReady && readEnable;
            accW = mReady && writeEnable;
            oldW = mem[readAddress];
            newW = laneMerge(mem[writeAddress], writeData, writeByteEnable);
            wfW  = (accW && writeAddress == readAddress) ? newW : oldW;
            expBv  = pendBv;
            expBd  = pendBd;
            pendBv = accR;
            pendBd = accR ? oldW : 32'h0;
            expAv  = accR;
            expAd  = accR ? wfW : 32'h0;
            if (accW) mem[writeAddress] = newW;
            if (clearLeft > 0) begin
                mem[DEPTH - clearLeft] = 32'h0;
                clearLeft--;
                if (clearLeft == 0) mReady = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (modelStarted) begin
            check("A.ready", 32'(rdyA), 32'(mReady));
            check("B.ready", 32'(rdyB), 32'(mReady));
            check("A.readValid", 32'(rvA), 32'(expAv));
            check("B.readValid", 32'(rvB), 32'(expBv));
            check("A.readData", rdA, expAd);
            check("B.readData", rdB, expBd);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        readEnable      = 1'b0;
        writeEnable     = 1'b0;
        writeByteEnable = '0;
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
        writeEnable = 1'b1; writeAddress = a; writeData = d; writeByteEnable = m;
    endtask

    task automatic doRead(input logic [AW-1:0] a);
        readEnable = 1'b1; readAddress = a;
    endtask

    initial begin
        // Power-up clear: ready low for DEPTH cycles after the reset edge.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            check("clear_ready_low", 32'(rdyA), 32'd0);
            tick();
        end
        @(negedge clock);
        check("clear_ready_high", 32'(rdyA), 32'd1);
        check("clear_ready_high_B", 32'(rdyB), 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            doRead(AW'(i));
            tick();
        end
        idle();
        @(negedge clock);
        check("zero_read_valid", 32'(rvA), 32'd1);
        check("zero_read_data", rdA, 32'h0000_0000);
        tick();
        tick();

        // Byte-mask merge.
        doWrite(4'd3, 32'hAABB_CCDD, 4'b1111);
        tick();
        doWrite(4'd3, 32'h1122_3344, 4'b0101);
        tick();
        idle();
        doRead(4'd3);
        tick();
        idle();
        @(negedge clock);
        check("mask_merge_A", rdA, 32'hAA22_CC44);
        tick();
        @(negedge clock);
        check("mask_merge_B", rdB, 32'hAA22_CC44);
        check("mask_merge_B_valid", 32'(rvB), 32'd1);

        // Latency-2 pipelined reads.
        doWrite(4'd1, 32'h1111_1111, 4'b1111);
        tick();
        doWrite(4'd2, 32'h2222_2222, 4'b1111);
        tick();
        doWrite(4'd3, 32'h3333_3333, 4'b1111);
        tick();
        idle();
        doRead(4'd1);
        tick();
        @(negedge clock);
        check("lat2_first_not_yet", 32'(rvB), 32'd0);
        doRead(4'd2);
        tick();
        @(negedge clock);
        check("lat2_data1", rdB, 32'h1111_1111);
        doRead(4'd3);
        tick();
        idle();
        @(negedge clock);
        check("lat2_data2", rdB, 32'h2222_2222);
        tick();
        @(negedge clock);
        check("lat2_data3", rdB, 32'h3333_3333);
        tick();
        @(negedge clock);
        check("lat2_after_valid", 32'(rvB), 32'd0);
        check("lat2_after_data", rdB, 32'h0);

        // Same-address collision, then re-read.
        doWrite(4'd5, 32'hFFFF_FFFF, 4'b0011);
        doRead(4'd5);
        tick();
        idle();
        doRead(4'd5);
        @(negedge clock);
        check("collision_write_first", rdA, 32'h0000_FFFF);
        tick();
        idle();
        @(negedge clock);
        check("collision_read_first", rdB, 32'h0000_0000);
        check("collision_read_first_valid", 32'(rvB), 32'd1);
        check("reread_write_first", rdA, 32'h0000_FFFF);
        tick();
        @(negedge clock);
        check("reread_read_first", rdB, 32'h0000_FFFF);
        tick();

        // Reset one cycle after a read: the latency-2 result never appears.
        doRead(4'd7);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int j = 0; j < 7; j++) begin
            doWrite(AW'(8 + j), 32'hDEAD_BEEF, 4'b1111);
            @(negedge clock);
            check("flushed_valid", 32'(rvB), 32'd0);
            check("flushed_data", rdB, 32'h0);
            tick();
        end

        // Reset again mid-clear (count 7): clear restarts from address 0.
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            doWrite(AW'(i), 32'hCAFE_F00D, 4'b1111);
            @(negedge clock);
            check("restart_ready_low", 32'(rdyA), 32'd0);
            tick();
        end
        idle();
        @(negedge clock);
        check("restart_ready_high", 32'(rdyA), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            doRead(AW'(i));
            tick();
            @(negedge clock);
            check("restart_mem_zero", rdA, 32'h0);
        end
        idle();
        tick();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
